// File: rtl/alu_regs_pkg.sv
// Shared constants for the alu_regs register slice: default width and ld bit indices.
package alu_regs_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned LD_W      = 4;

    localparam int unsigned LD_A   = 0;
    localparam int unsigned LD_B   = 1;
    localparam int unsigned LD_OUT = 2;
    localparam int unsigned LD_PC  = 3;

    typedef logic [LD_W-1:0] ld_t;

endpackage

// File: rtl/alu_regs_if.sv
// Operand/load-enable inputs and register outputs of alu_regs, grouped as one bus.
interface alu_regs_if
    import alu_regs_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) ();

    logic [WIDTH-1:0] sel_in;
    logic [WIDTH-1:0] imm;
    ld_t              ld;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] out_port;
    logic [WIDTH-1:0] pc;
    logic             carry;

    modport master (
        output sel_in, imm, ld,
        input  reg_a, reg_b, out_port, pc, carry
    );

    modport slave (
        input  sel_in, imm, ld,
        output reg_a, reg_b, out_port, pc, carry
    );

endinterface

// File: rtl/alu_regs_reg_ld.sv
// reg_ld: WIDTH-bit register with asynchronous active-high reset and load enable.
module reg_ld #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = ld_i ? d_i : q_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/alu_regs.sv
// alu_regs: adder (sel_in + imm) feeding A/B/OUT registers and a loadable PC.
// Define ALU_REGS_CARRY_FLAG_EN to build the registered carry flag; otherwise carry is tied 0.
module alu_regs
    import alu_regs_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input logic       clk,
    input logic       rst,
    alu_regs_if.slave bus
);

    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

`ifdef ALU_REGS_CARRY_FLAG_EN
    logic cout;
    logic carry_q;

    assign {cout, result} = {1'b0, bus.sel_in} + {1'b0, bus.imm};

    // Carry tracks the adder every edge, independent of ld.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= cout;
        end
    end

    assign bus.carry = carry_q;
`else
    assign result    = bus.sel_in + bus.imm;
    assign bus.carry = 1'b0;
`endif

    reg_ld #(.WIDTH(WIDTH)) u_reg_a (
        .clk  (clk),
        .rst  (rst),
        .ld_i (bus.ld[LD_A]),
        .d_i  (result),
        .q_o  (a_q)
    );

    reg_ld #(.WIDTH(WIDTH)) u_reg_b (
        .clk  (clk),
        .rst  (rst),
        .ld_i (bus.ld[LD_B]),
        .d_i  (result),
        .q_o  (b_q)
    );

    reg_ld #(.WIDTH(WIDTH)) u_reg_out (
        .clk  (clk),
        .rst  (rst),
        .ld_i (bus.ld[LD_OUT]),
        .d_i  (result),
        .q_o  (out_q)
    );

    // Jump takes priority; otherwise free-run with silent wrap.
    always_comb begin
        pc_d = bus.ld[LD_PC] ? result : pc_q + WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.reg_a    = a_q;
    assign bus.reg_b    = b_q;
    assign bus.out_port = out_q;
    assign bus.pc       = pc_q;

endmodule

// File: tb/tb_alu_regs.sv
// Self-checking bench for alu_regs: directed scenarios plus random traffic against a plain model.
module tb_alu_regs;
    import alu_regs_pkg::*;

    localparam int unsigned W   = 4;
    localparam int unsigned MOD = 1 << W;

`ifdef ALU_REGS_CARRY_FLAG_EN
    localparam bit CARRY_EN = 1'b1;
`else
    localparam bit CARRY_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    alu_regs_if #(.WIDTH(W)) bus ();

    alu_regs #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Model state: plain integers, wrapped modulo 2^W.
    int m_a, m_b, m_out, m_pc, m_carry;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_out = 0; m_pc = 0; m_carry = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".reg_a"},    int'(bus.reg_a),    m_a);
        check({tag, ".reg_b"},    int'(bus.reg_b),    m_b);
        check({tag, ".out_port"}, int'(bus.out_port), m_out);
        check({tag, ".pc"},       int'(bus.pc),       m_pc);
        check({tag, ".carry"},    int'(bus.carry),    m_carry);
    endtask

    // Apply inputs, advance one edge, update model from the rules, compare 1 unit later.
    task automatic step(input int sel, input int im, input int ld, input string tag);
        int sum, res, cout;
        bus.sel_in = W'(sel);
        bus.imm    = W'(im);
        bus.ld     = ld_t'(ld);
        sum  = sel + im;
        res  = sum % MOD;
        cout = sum / MOD;
        @(posedge clk);
        if (ld[LD_A])   m_a   = res;
        if (ld[LD_B])   m_b   = res;
        if (ld[LD_OUT]) m_out = res;
        m_pc    = ld[LD_PC] ? res : (m_pc + 1) % MOD;
        m_carry = CARRY_EN ? cout : 0;
        #1;
        compare_all(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst        = 1'b1;
        bus.sel_in = W'($urandom);
        bus.imm    = W'($urandom);
        bus.ld     = ld_t'($urandom);
        model_reset();
        #1;
        // Outputs must already be zero before the first clock edge.
        compare_all("reset_pre_clk");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Free-running PC for 17 edges: 1..15, 0, 1.
        for (int i = 0; i < 17; i++) begin
            step($urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1), 0, "freerun");
            check("freerun.pc_literal", int'(bus.pc), (i + 1) % 16);
        end
        check("freerun.a_literal", int'(bus.reg_a), 0);

        // Load A: 3 + 4 = 7.
        begin
            int b_before;
            b_before = m_b;
            step(3, 4, 4'b0001, "load_a");
            check("load_a.literal", int'(bus.reg_a), 7);
            check("load_a.carry_literal", int'(bus.carry), 0);
            check("load_a.b_held", int'(bus.reg_b), b_before);
        end

        // Carry: 15 + 2 = 17 -> reg_b 1, cout 1.
        step(15, 2, 4'b0010, "carry");
        check("carry.b_literal", int'(bus.reg_b), 1);
        check("carry.flag_literal", int'(bus.carry), CARRY_EN ? 1 : 0);

        // Jump from pc = 5 to 10, then free-run to 11.
        do_reset();
        repeat (5) step($urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1), 0, "to_five");
        check("jump.pc_before", int'(bus.pc), 5);
        step(0, 10, 4'b1000, "jump");
        check("jump.pc_literal", int'(bus.pc), 10);
        step(0, 0, 4'b0000, "jump_next");
        check("jump_next.pc_literal", int'(bus.pc), 11);

        // Multi-load: 1 + 1 = 2 into A, B and OUT on one edge.
        step(1, 1, 4'b0111, "multi");
        check("multi.a_literal",   int'(bus.reg_a),    2);
        check("multi.b_literal",   int'(bus.reg_b),    2);
        check("multi.out_literal", int'(bus.out_port), 2);

        // Mid-cycle reset pulse with a full load pending.
        bus.sel_in = 4'd5;
        bus.imm    = 4'd6;
        bus.ld     = 4'b1111;
        #1 rst = 1'b1;
        #1;
        model_reset();
        compare_all("mid_rst");
        #1 rst = 1'b0;
        step(9, 3, 4'b0000, "after_rst");
        check("after_rst.pc_literal", int'(bus.pc), 1);
        check("after_rst.out_literal", int'(bus.out_port), 0);

        // Random traffic, including read-after-write of the fed-back registers.
        for (int i = 0; i < 300; i++) begin
            int src;
            int sel;
            src = $urandom_range(0, 3);
            case (src)
                0: sel = m_a;
                1: sel = m_b;
                default: sel = $urandom_range(0, MOD - 1);
            endcase
            step(sel, $urandom_range(0, MOD - 1), $urandom_range(0, 15), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_regs.md
ALU_REGS -- requirements
Module: alu_regs

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the data width of the registers, adder and PC.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port sel_in, input, WIDTH bits: the operand from the upstream 4-way selector output.
REQ-005 The module SHALL have port imm, input, WIDTH bits: the immediate field of the current instruction.
REQ-006 The module SHALL have port ld, input, 4 bits, active-high load enables: bit0 = A, bit1 = B, bit2 = OUT, bit3 = PC.
REQ-007 The module SHALL have port reg_a, output, WIDTH bits: register A, fed back to selector in0.
REQ-008 The module SHALL have port reg_b, output, WIDTH bits: register B, fed back to selector in1.
REQ-009 The module SHALL have port out_port, output, WIDTH bits: the OUT register.
REQ-010 The module SHALL have port pc, output, WIDTH bits: the program counter.
REQ-011 The module SHALL have port carry, output, 1 bit: the registered carry flag.

Function
REQ-012 The module SHALL compute a combinational sum = sel_in + imm, WIDTH+1 bits wide; result = sum[WIDTH-1:0] and cout = sum[WIDTH].
REQ-013 On each rising clk edge, every register whose ld bit is 1 SHALL load result; registers with a 0 ld bit SHALL hold.
REQ-014 When several ld bits are set together, all selected registers SHALL load the same result on the same edge.
REQ-015 When ld[3] = 0, pc SHALL increment by 1 each edge and wrap from 2^WIDTH-1 to 0 without any flag.
REQ-016 When ld[3] = 1, pc SHALL load result (jump) and SHALL NOT increment on that edge.
REQ-017 Latency SHALL be one clock from sel_in/imm/ld to the updated register outputs, with no combinational path from inputs to outputs.
REQ-018 A read and a write of the same register in one cycle SHALL use the old value for the adder and present the new value after the edge.

Reset
REQ-019 rst = 1 SHALL immediately clear reg_a, reg_b, out_port, pc and carry to 0, independent of clk.
REQ-020 An rst pulse asserted in the middle of a cycle SHALL discard any pending load, and the first edge after release SHALL operate normally (pc 0 -> 1 when ld[3] = 0).

Configuration
REQ-021 With macro ALU_REGS_CARRY_FLAG_EN defined, carry SHALL load cout on every rising edge, regardless of ld.
REQ-022 Without ALU_REGS_CARRY_FLAG_EN, carry SHALL be constant 0 and no carry flip-flop SHALL be built.

Structure
REQ-023 A shared package SHALL hold the WIDTH default and the ld bit-index constants (LD_A = 0, LD_B = 1, LD_OUT = 2, LD_PC = 3).
REQ-024 One sub-module, reg_ld, SHALL implement a WIDTH-bit register with async reset and load enable; it SHALL be instantiated for A, B and OUT.
REQ-025 The PC SHALL be a separate counter inside alu_regs, because it has increment-or-load behaviour.

Verification
REQ-026 Reset scenario: assert rst with arbitrary inputs -> all outputs read 0 immediately, before any clk edge.
REQ-027 Free-running PC scenario: ld = 0000 for 17 edges after reset -> pc steps 1, 2, ..., 15, 0, 1 and reg_a, reg_b and out_port stay 0.
REQ-028 Load-A scenario: sel_in = 0011, imm = 0100, ld = 0001 -> after the edge, reg_a = 0111, carry = 0 and reg_b is unchanged.
REQ-029 Carry scenario: sel_in = 1111, imm = 0010, ld = 0010 -> reg_b = 0001 and carry = 1 when the macro is defined, 0 when it is not.
REQ-030 Jump scenario: with pc = 0101, sel_in = 0000, imm = 1010, ld = 1000 -> pc = 1010 on the next edge and then 1011 once ld = 0000.
REQ-031 Multi-load scenario: sel_in = 0001, imm = 0001, ld = 0111 -> reg_a, reg_b and out_port all read 0010 after a single edge.
